i2c_aud_target: RTL and testbench

I2C write-only target (responder) for the audio-codec configuration path. It is the far end of the I2C_AUD initiator. It oversamples I2C_SCLK/I2C_SDAT on the system clock, detects START/STOP, and matches a 7-bit device address. It acknowledges and captures two data bytes, then presents them as a single-cycle register-write strobe. It is used as a codec model in simulation and as an on-chip configuration sink.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 37 +++
 rtl/i2c_aud_target.sv | 164 ++++++++++++++++
 tb/tb_i2c_aud_target.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the audio-codec configuration path (initiator and target).
// Holds the target FSM state encoding and the R/W bit value for a write.
// No logic; imported by i2c_aud_target and the I2C_AUD initiator.
package i2c_pkg;

  // States of the write-only target FSM.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_DATA1     = 3'd3,
    ST_ACK1      = 3'd4,
    ST_DATA2     = 3'd5,
    ST_ACK2      = 3'd6,
    ST_WAIT_STOP = 3'd7
  } t_i2c_tgt_state;

  // Value of the R/W bit (LSB of the address byte) for a write transfer.
  localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Purpose: 2-flop synchronizer for one asynchronous bus line plus rise/fall pulses.
// Latency: lvl follows din after 2 clk; rise/fall pulse in the same cycle lvl changes.
// Backpressure: none (free-running sampler).
// Ports: clk, rst (async, active high), din (async line), lvl (synchronized level),
//        rise/fall (one-cycle pulses on a synchronized 0->1 / 1->0 transition).
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign lvl  = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/i2c_aud_target.sv
// Purpose: write-only I2C target; matches DEV_ADDR, ACKs and captures two data bytes,
//          then presents them with a one-cycle VALID strobe.
// Latency: bus events act 3 Clk after the pin change; OE follows the SCL fall by 3 Clk.
// Backpressure: none; the target never stretches SCL and every write is accepted.
// Ports: Clk, Reset (async, active high), I2C_SCLK/I2C_SDAT_IN (async bus inputs),
//        I2C_SDAT_OE (1 = pull SDA low), DATA1/DATA2 (last complete write), VALID, BUSY.
module i2c_aud_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  output logic [7:0] DATA1,
  output logic [7:0] DATA2,
  output logic       VALID,
  output logic       BUSY
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.RST_VAL(1'b1)) u_scl_sync (
    .clk  (Clk),
    .rst  (Reset),
    .din  (I2C_SCLK),
    .lvl  (scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sda_sync (
    .clk  (Clk),
    .rst  (Reset),
    .din  (I2C_SDAT_IN),
    .lvl  (sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  t_i2c_tgt_state state, state_nxt;

  logic [2:0] bit_cnt;
  logic       byte_done;   // 8 bits of the current byte have been shifted in
  logic [7:0] shreg;
  logic [7:0] byte1;       // first data byte, held until ACK2 completes
  logic       addr_ok;     // address phase was ACKed in this transaction
  logic       addr_match;
  logic       shifting;
  logic       start_det;
  logic       stop_det;

  // SCL high now and not just risen means it was also high in the previous
  // sample, so an SDA edge coinciding with an SCL rise is not a START/STOP.
  assign start_det = sda_fall & scl_lvl & ~scl_rise;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise;

  assign addr_match = (shreg[7:1] == DEV_ADDR) && (shreg[0] == I2C_WRITE);
  assign shifting   = (state == ST_ADDR) || (state == ST_DATA1) || (state == ST_DATA2);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; START/STOP override any bit handling in the same cycle.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ST_ADDR;
    end else if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (scl_fall) begin
      case (state)
        ST_ADDR:     if (byte_done) state_nxt = ST_ADDR_ACK;
        ST_ADDR_ACK: state_nxt = addr_match ? ST_DATA1 : ST_WAIT_STOP;
        ST_DATA1:    if (byte_done) state_nxt = ST_ACK1;
        ST_ACK1:     state_nxt = ST_DATA2;
        ST_DATA2:    if (byte_done) state_nxt = ST_ACK2;
        ST_ACK2:     state_nxt = ST_WAIT_STOP;
        default:     state_nxt = state;
      endcase
    end
  end

  // Outputs decoded from state. OE is combinational on the state so an
  // asynchronous reset releases SDA without waiting for a clock edge.
  always_comb begin
    I2C_SDAT_OE = 1'b0;
    BUSY        = 1'b0;
    case (state)
      ST_ADDR_ACK: begin
        I2C_SDAT_OE = addr_match;
        BUSY        = addr_match;
      end
      ST_DATA1, ST_DATA2: begin
        BUSY = 1'b1;
      end
      ST_ACK1, ST_ACK2: begin
        I2C_SDAT_OE = 1'b1;
        BUSY        = 1'b1;
      end
      ST_WAIT_STOP: begin
        BUSY = addr_ok;
      end
      default: begin
        I2C_SDAT_OE = 1'b0;
        BUSY        = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      shreg     <= 8'h00;
      byte1     <= 8'h00;
      addr_ok   <= 1'b0;
      DATA1     <= 8'h00;
      DATA2     <= 8'h00;
      VALID     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        addr_ok   <= 1'b0;
      end else begin
        if (shifting && scl_rise) begin
          shreg   <= {shreg[6:0], sda_lvl};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
          end
        end
        if (shifting && scl_fall && byte_done) begin
          byte_done <= 1'b0;
          if (state == ST_DATA1) begin
            byte1 <= shreg;
          end
        end
        if ((state == ST_ADDR_ACK) && scl_fall && addr_match) begin
          addr_ok <= 1'b1;
        end
        // End of the ACK2 clock: publish both bytes together with VALID.
        if ((state == ST_ACK2) && scl_fall) begin
          DATA1 <= byte1;
          DATA2 <= shreg;
          VALID <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_aud_target.sv
// Bench for i2c_aud_target: table of directed write transactions, randomized
// transactions checked against a transaction-level model, and hand-written
// sequences for repeated START, read request and reset during an ACK.
module tb_i2c_aud_target;
  import i2c_pkg::*;

  localparam int H2 = 5;  // quarter SCL period in Clk cycles (SCL phases are 10 Clk)

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       I2C_SDAT_OE;
  logic [7:0] DATA1, DATA2;
  logic       VALID, BUSY;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_m & ~I2C_SDAT_OE;

  i2c_aud_target #(.DEV_ADDR(7'h1A)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .I2C_SCLK    (scl_m),
    .I2C_SDAT_IN (sda_line),
    .I2C_SDAT_OE (I2C_SDAT_OE),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .VALID       (VALID),
    .BUSY        (BUSY)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // VALID monitor: counts strobe cycles and checks OE drops in the VALID cycle.
  int   valid_cnt = 0;
  int   valid_oe_bad = 0;
  logic oe_prev = 1'b0;
  always @(negedge Clk) begin
    oe_prev <= I2C_SDAT_OE;
    if (VALID === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      if (I2C_SDAT_OE !== 1'b0 || oe_prev !== 1'b1) valid_oe_bad <= valid_oe_bad + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] bytes;   // byte 0 (address) in bits [7:0]
    int          n;       // complete bytes sent
    int          part;    // extra bits of byte n before STOP
    logic [3:0]  acks;    // expected ACK per complete byte
    logic        v;       // expected VALID strobe
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic        busy;    // expected BUSY during the address ACK clock
  } vec_t;

  vec_t tbl[8];
  logic [7:0] mdl_d1, mdl_d2;

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SCL clock with SDA driven to b; samples OE and BUSY mid high phase.
  task automatic clock_bit(input logic b, output logic oe_s, output logic busy_s);
    sda_m = b;
    tick(H2);
    scl_m = 1'b1;
    tick(H2);
    oe_s   = I2C_SDAT_OE;
    busy_s = BUSY;
    tick(H2);
    scl_m = 1'b0;
    tick(H2);
  endtask

  task automatic do_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      tick(H2);
      scl_m = 1'b1;
    end
    tick(H2);
    sda_m = 1'b0;
    tick(H2);
    scl_m = 1'b0;
    tick(H2);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    tick(H2);
    scl_m = 1'b1;
    tick(H2);
    sda_m = 1'b1;
    tick(2 * H2);
  endtask

  task automatic send(input logic [3:0][7:0] bytes, input int n, input int part,
                      output logic [3:0] acks, output logic oe_data, output logic busy_a);
    logic o, b;
    acks = 4'b0000;
    oe_data = 1'b0;
    busy_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        clock_bit(bytes[i][j], o, b);
        oe_data = oe_data | o;
      end
      clock_bit(1'b1, o, b);
      acks[i] = o;
      if (i == 0) busy_a = b;
    end
    for (int j = 0; j < part; j++) begin
      clock_bit(bytes[n][7-j], o, b);
      oe_data = oe_data | o;
    end
  endtask

  // Transaction-level reference: ACKs come only for a write to 0x1A and only for
  // the address plus two data bytes; a write with both data bytes updates DATA.
  task automatic model(input logic [3:0][7:0] bytes, input int n,
                       output logic [3:0] acks, output logic v, output logic busy);
    logic ok;
    ok = (bytes[0] == 8'h34);
    acks = 4'b0000;
    for (int i = 0; i < n; i++) acks[i] = ok && (i < 3);
    v = ok && (n >= 3);
    busy = ok;
    if (v) begin
      mdl_d1 = bytes[1];
      mdl_d2 = bytes[2];
    end
  endtask

  task automatic run_txn(input string name, input vec_t t);
    int v0;
    logic [3:0] acks;
    logic oe_data, busy_a;
    v0 = valid_cnt;
    do_start();
    send(t.bytes, t.n, t.part, acks, oe_data, busy_a);
    do_stop();
    tick(4);
    check({name, " acks"}, 32'(acks), 32'(t.acks));
    check({name, " oe_in_data"}, 32'(oe_data), 32'(0));
    check({name, " valid_cnt"}, 32'(valid_cnt - v0), 32'(t.v));
    check({name, " DATA1"}, 32'(DATA1), 32'(t.d1));
    check({name, " DATA2"}, 32'(DATA2), 32'(t.d2));
    check({name, " busy_addr_ack"}, 32'(busy_a), 32'(t.busy));
    check({name, " busy_after_stop"}, 32'(BUSY), 32'(0));
  endtask

  initial begin
    vec_t r;
    logic [3:0] acks;
    logic oe_data, busy_a;
    int v0;

    tbl[0] = '{32'h00F03C34, 3, 0, 4'b0111, 1'b1, 8'h3C, 8'hF0, 1'b1};  // clean write
    tbl[1] = '{32'h00F03CC3, 3, 0, 4'b0000, 1'b0, 8'h3C, 8'hF0, 1'b0};  // address mismatch
    tbl[2] = '{32'h00000035, 1, 0, 4'b0000, 1'b0, 8'h3C, 8'hF0, 1'b0};  // read request
    tbl[3] = '{32'h0055AA34, 2, 4, 4'b0011, 1'b0, 8'h3C, 8'hF0, 1'b1};  // aborted mid byte
    tbl[4] = '{32'h56341234, 4, 0, 4'b0111, 1'b1, 8'h12, 8'h34, 1'b1};  // extra byte NACKed
    tbl[5] = '{32'h00F03C36, 3, 0, 4'b0000, 1'b0, 8'h12, 8'h34, 1'b0};  // neighbour address
    tbl[6] = '{32'h00FF0034, 3, 0, 4'b0111, 1'b1, 8'h00, 8'hFF, 1'b1};  // data extremes
    tbl[7] = '{32'h00000034, 1, 0, 4'b0001, 1'b0, 8'h00, 8'hFF, 1'b1};  // STOP after addr ACK

    // Reset state
    tick(3);
    check("rst OE", 32'(I2C_SDAT_OE), 32'(0));
    check("rst VALID", 32'(VALID), 32'(0));
    check("rst BUSY", 32'(BUSY), 32'(0));
    check("rst DATA1", 32'(DATA1), 32'(0));
    check("rst DATA2", 32'(DATA2), 32'(0));
    Reset = 1'b0;
    tick(5);

    for (int i = 0; i < 8; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);
    mdl_d1 = 8'h00;
    mdl_d2 = 8'hFF;

    // Randomized transactions against the model
    for (int k = 0; k < 20; k++) begin
      r.bytes = $urandom;
      if ($urandom_range(0, 2) != 0) r.bytes[7:0] = 8'h34;
      r.n    = $urandom_range(1, 4);
      r.part = (r.n < 4) ? $urandom_range(0, 7) : 0;
      model(r.bytes, r.n, r.acks, r.v, r.busy);
      r.d1 = mdl_d1;
      r.d2 = mdl_d2;
      run_txn($sformatf("rnd%0d", k), r);
    end

    // Read request leaves the FSM parked in WAIT_STOP
    do_start();
    send(32'h00000035, 1, 0, acks, oe_data, busy_a);
    tick(4);
    check("read state", 32'(dut.state), 32'(ST_WAIT_STOP));
    check("read BUSY", 32'(BUSY), 32'(0));
    check("read ack", 32'(acks), 32'(0));
    do_stop();
    tick(4);
    check("read idle", 32'(dut.state), 32'(ST_IDLE));

    // Repeated START restarts the transfer; only the second one completes
    v0 = valid_cnt;
    do_start();
    send(32'h00001134, 2, 0, acks, oe_data, busy_a);
    check("rs first acks", 32'(acks), 32'(4'b0011));
    do_start();
    send(32'h00332234, 3, 0, acks, oe_data, busy_a);
    check("rs second acks", 32'(acks), 32'(4'b0111));
    do_stop();
    tick(4);
    check("rs valid_cnt", 32'(valid_cnt - v0), 32'(1));
    check("rs DATA1", 32'(DATA1), 32'(8'h22));
    check("rs DATA2", 32'(DATA2), 32'(8'h33));

    // Reset during the address ACK clock releases OE without a clock edge
    do_start();
    for (int j = 7; j >= 0; j--) begin
      logic o, b;
      clock_bit(1'(8'h34 >> j), o, b);
    end
    sda_m = 1'b1;
    tick(H2);
    scl_m = 1'b1;
    tick(2);
    check("ack OE before reset", 32'(I2C_SDAT_OE), 32'(1));
    check("ack BUSY before reset", 32'(BUSY), 32'(1));
    #1 Reset = 1'b1;
    #1;
    check("async rst OE", 32'(I2C_SDAT_OE), 32'(0));
    check("async rst BUSY", 32'(BUSY), 32'(0));
    check("async rst DATA1", 32'(DATA1), 32'(0));
    check("async rst DATA2", 32'(DATA2), 32'(0));
    check("async rst VALID", 32'(VALID), 32'(0));
    tick(4);
    Reset = 1'b0;
    tick(10);
    mdl_d1 = 8'h00;
    mdl_d2 = 8'h00;

    // Fresh START after reset works normally
    r.bytes = 32'h00A55A34;
    r.n = 3;
    r.part = 0;
    model(r.bytes, r.n, r.acks, r.v, r.busy);
    r.d1 = mdl_d1;
    r.d2 = mdl_d2;
    run_txn("post_reset", r);

    tick(5);
    check("valid with OE drop", 32'(valid_oe_bad), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
